codec_cfg_seq: RTL and testbench

Configuration sequencer directly upstream of the I2C master. After reset it walks a constant register table and packs each group of five 16-bit register words into an 88-bit frame (device address byte plus 10 payload bytes). It hands each frame to the I2C master with a one-cycle start pulse and waits for the master's `configured` flag, retrying on timeout. It reports `done` to the top level once every frame has been acknowledged.

---
 rtl/codec_cfg_pkg.sv | 42 ++++
 rtl/codec_cfg_rom.sv | 12 +
 rtl/codec_cfg_seq.sv | 110 +++++++++++
 tb/tb_codec_cfg_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: state encoding, frame geometry and the default WM8731 register table
package codec_cfg_pkg;
    localparam logic [2:0] S_POWERUP   = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_PULSE     = 3'd2;
    localparam logic [2:0] S_WAIT_LOW  = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam int FRAME_BITS      = 88;
    localparam int WORDS_PER_FRAME = 5;

    // WM8731 words are {7-bit register address, 9-bit value}
    localparam logic [15:0] WM_RESET  = 16'h1E00;
    localparam logic [15:0] WM_POWER  = 16'h0C00;
    localparam logic [15:0] WM_LLINE  = 16'h0017;
    localparam logic [15:0] WM_RLINE  = 16'h0217;
    localparam logic [15:0] WM_LHP    = 16'h0479;
    localparam logic [15:0] WM_RHP    = 16'h0679;
    localparam logic [15:0] WM_APATH  = 16'h0812;
    localparam logic [15:0] WM_DPATH  = 16'h0A06;
    localparam logic [15:0] WM_IFACE  = 16'h0E02;
    localparam logic [15:0] WM_ACTIVE = 16'h1201;

    function automatic logic [15:0] wm8731_word(input int idx);
        case (idx)
            0:       return WM_RESET;
            1:       return WM_POWER;
            2:       return WM_LLINE;
            3:       return WM_RLINE;
            4:       return WM_LHP;
            5:       return WM_RHP;
            6:       return WM_APATH;
            7:       return WM_DPATH;
            8:       return WM_IFACE;
            9:       return WM_ACTIVE;
            default: return 16'h0000;
        endcase
    endfunction
endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: synchronous register-word table, one cycle read latency
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_50,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);
    always_ff @(posedge clk_50) data <= wm8731_word(int'(addr));
endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: walks the register table, packs 5-word frames and hands them to the I2C master with retry
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         NUM_FRAMES     = 2,
    parameter int         POWERUP_CYCLES = 1_000_000,
    parameter int         GAP_CYCLES     = 4096,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    parameter int         MAX_RETRIES    = 3,
    localparam int        FW             = $clog2(NUM_FRAMES + 1)
) (
    input  logic                  clk_50,
    input  logic                  reset,
    input  logic                  restart,
    output logic                  i2c_start,
    output logic [0:FRAME_BITS-1] i2c_data,
    input  logic                  i2c_configured,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [FW-1:0]         frame_idx
);
    localparam int CNT_MAX = POWERUP_CYCLES > TIMEOUT_CYCLES
        ? (POWERUP_CYCLES > GAP_CYCLES ? POWERUP_CYCLES : GAP_CYCLES)
        : (TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES);
    localparam int CW     = $clog2(CNT_MAX + 1) + 1;
    localparam int RW     = $clog2(MAX_RETRIES + 1) + 1;
    localparam int ADDR_W = $clog2(WORDS_PER_FRAME * NUM_FRAMES + 1);

    localparam logic [CW-1:0] PU_END   = CW'(POWERUP_CYCLES);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LOAD_END = CW'(WORDS_PER_FRAME);
    localparam logic [RW-1:0] RT_MAX   = RW'(MAX_RETRIES);

    if (NUM_FRAMES < 1) begin : g_bad_num_frames
        $error("codec_cfg_seq: NUM_FRAMES must be at least 1");
    end

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     retry;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    assign rom_addr  = ADDR_W'(WORDS_PER_FRAME * int'(frame_idx) + int'(cnt));
    assign i2c_start = state == S_PULSE;
    assign done      = state == S_DONE;
    assign error     = state == S_ERROR;
    assign busy      = !done && !error;

    codec_cfg_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk_50(clk_50),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state     <= S_POWERUP;
            cnt       <= '0;
            retry     <= '0;
            frame_idx <= '0;
            i2c_data  <= '0;
        end else begin
            cnt <= &cnt ? cnt : cnt + 1'b1;
            case (state)
                S_POWERUP: if (cnt == PU_END) begin
                    state <= S_LOAD;
                    cnt   <= '0;
                end
                // ROM word k arrives at cnt k+1 and is shifted in from the tail
                S_LOAD: begin
                    if (cnt == '0) i2c_data[0:7] <= DEV_ADDR;
                    else i2c_data[8:FRAME_BITS-1] <= {i2c_data[24:FRAME_BITS-1], rom_data};
                    if (cnt == LOAD_END) state <= S_PULSE;
                end
                S_PULSE: begin
                    state <= S_WAIT_LOW;
                    cnt   <= '0;
                end
                S_WAIT_LOW, S_WAIT_HIGH: begin
                    if (state == S_WAIT_HIGH && i2c_configured) begin
                        retry     <= '0;
                        frame_idx <= frame_idx + 1'b1;
                        state     <= S_GAP;
                        cnt       <= '0;
                    end else if (state == S_WAIT_LOW && !i2c_configured) begin
                        state <= S_WAIT_HIGH;
                    end else if (cnt >= TO_END) begin
                        state <= retry < RT_MAX ? S_GAP : S_ERROR;
                        retry <= retry < RT_MAX ? retry + 1'b1 : retry;
                        cnt   <= '0;
                    end
                end
                S_GAP: if (cnt == GAP_END) begin
                    state <= frame_idx < FW'(NUM_FRAMES) ? S_LOAD : S_DONE;
                    cnt   <= '0;
                end
                default: if (restart) begin
                    frame_idx <= '0;
                    retry     <= '0;
                    state     <= S_LOAD;
                    cnt       <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: randomized attempt-level model with scoreboard of expected frames per start pulse
module tb_codec_cfg_seq;
    localparam int PU = 100;
    localparam int GAP = 10;
    localparam int TO = 200;
    localparam int NF = 2;
    localparam int MR = 3;
    localparam logic [7:0] DEV = 8'h34;
    localparam logic [15:0] TBL [10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                                         16'h0679, 16'h0812, 16'h0A06, 16'h0E02, 16'h1201};

    typedef struct {
        int f;
        int drop;
        int ack;
    } attempt_t;

    logic        clk_50 = 0;
    logic        reset = 1;
    logic        restart = 0;
    logic        i2c_configured = 0;
    logic        i2c_start, busy, done, error;
    logic [0:87] i2c_data;
    logic [1:0]  frame_idx;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int ack_cyc = 0;
    attempt_t    plan_q[$];
    logic [0:87] exp_q[$];

    codec_cfg_seq #(
        .POWERUP_CYCLES(PU),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50        (clk_50),
        .reset         (reset),
        .restart       (restart),
        .i2c_start     (i2c_start),
        .i2c_data      (i2c_data),
        .i2c_configured(i2c_configured),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .frame_idx     (frame_idx)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [0:87] frame_of(input int f);
        logic [0:87] r;
        r[0:7] = DEV;
        for (int k = 0; k < 5; k++) r[8 + 16 * k +: 16] = TBL[5 * f + k];
        return r;
    endfunction

    // A frame that keeps timing out is abandoned after MR resends; otherwise it is acked once.
    task automatic plan_run(input int n0, input int n1, output logic exp_done, output int exp_f);
        int nfail[NF];
        nfail[0] = n0;
        nfail[1] = n1;
        exp_done = 1;
        exp_f = 0;
        for (int f = 0; f < NF && exp_done; f++) begin
            for (int a = 0; a < (nfail[f] > MR ? MR + 1 : nfail[f] + 1); a++) begin
                attempt_t x;
                x.f = f;
                x.drop = 3;
                x.ack = a < nfail[f] ? -1 : int'($urandom_range(150, 10));
                plan_q.push_back(x);
                exp_q.push_back(frame_of(f));
            end
            if (nfail[f] > MR) exp_done = 0;
            else exp_f = f + 1;
        end
    endtask

    initial begin
        logic prev;
        prev = 0;
        forever begin
            @(negedge clk_50);
            if (i2c_start) begin
                chk("start_one_cycle", prev, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_start: got start at cycle %0d, expected none", cyc);
                end else begin
                    chk("frame_data", i2c_data, exp_q.pop_front());
                end
            end
            prev = i2c_start;
        end
    end

    // I2C master stand-in: drops the flag drop cycles after start, raises it ack cycles after start
    initial begin
        attempt_t cur;
        int t;
        bit active;
        active = 0;
        t = 0;
        forever begin
            @(negedge clk_50);
            if (i2c_start) begin
                active = plan_q.size() != 0;
                if (active) cur = plan_q.pop_front();
                t = 0;
            end
            if (active) begin
                if (t == cur.drop) i2c_configured = 0;
                if (t == cur.ack) begin
                    i2c_configured = 1;
                    ack_cyc = cyc;
                    active = 0;
                    chk("idx_at_ack", frame_idx, cur.f);
                end
                t++;
            end
        end
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got no end of test by cycle %0d, expected end", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk_50);
            n++;
        end
        chk({name, "_idle_in_time"}, n < 20000, 1);
    endtask

    task automatic end_checks(input string name, input logic ed, input int ef);
        wait_idle(name);
        repeat (20) @(negedge clk_50);
        chk({name, "_done"}, done, ed);
        chk({name, "_error"}, error, !ed);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_frame_idx"}, frame_idx, ef);
        chk({name, "_frames_left"}, exp_q.size(), 0);
    endtask

    task automatic count_to_start(input string name, input int expect_n);
        int n;
        n = 0;
        do begin
            @(posedge clk_50);
            #1;
            restart = 0;
            n++;
        end while (!i2c_start && n < 1000);
        chk(name, n, expect_n);
    endtask

    task automatic restart_run(input string name, input int n0, input int n1);
        logic ed;
        int ef;
        plan_run(n0, n1, ed, ef);
        @(negedge clk_50);
        restart = 1;
        count_to_start({name, "_restart_latency"}, 7);
        end_checks(name, ed, ef);
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_start"}, i2c_start, 0);
        chk({name, "_data"}, i2c_data, 0);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_done"}, done, 0);
        chk({name, "_error"}, error, 0);
        chk({name, "_frame_idx"}, frame_idx, 0);
    endtask

    initial begin
        logic ed;
        int ef;
        int n;
        repeat (3) @(negedge clk_50);
        reset_checks("rst");

        plan_run(0, 0, ed, ef);
        reset = 0;
        count_to_start("first_start_cycle", PU + 7);
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk_50);
            #1;
            n++;
        end
        // flag seen one edge after the ack, then GAP_CYCLES+1 cycles in GAP
        chk("done_after_gap", cyc - ack_cyc, GAP + 2);
        end_checks("normal", ed, ef);

        plan_run(0, 0, ed, ef);
        @(negedge clk_50);
        restart = 1;
        count_to_start("stale_restart_latency", 7);
        n = 0;
        do begin
            @(posedge clk_50);
            #1;
            n++;
        end while (!i2c_start && n < 1000);
        repeat (6) @(negedge clk_50);
        restart = 1;
        @(negedge clk_50);
        restart = 0;
        @(negedge clk_50);
        chk("restart_ignored_idx", frame_idx, 1);
        chk("restart_ignored_busy", busy, 1);
        end_checks("stale", ed, ef);

        restart_run("timeout", MR + 1, 0);
        restart_run("recovery", 1, MR);
        for (int i = 0; i < 3; i++) restart_run("random", $urandom_range(4), $urandom_range(4));

        begin
            attempt_t x;
            x.f = 0;
            x.drop = 3;
            x.ack = -1;
            plan_q.push_back(x);
            exp_q.push_back(frame_of(0));
        end
        @(negedge clk_50);
        restart = 1;
        count_to_start("midrst_restart_latency", 7);
        repeat (10) @(negedge clk_50);
        reset = 1;
        @(posedge clk_50);
        #1;
        reset_checks("midrst");
        plan_run(0, 0, ed, ef);
        @(negedge clk_50);
        reset = 0;
        count_to_start("midrst_powerup_cycle", PU + 7);
        end_checks("midrst", ed, ef);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
